// File: rtl/hls_run_sequencer_pkg.sv
// Shared types for the HLS run sequencer: FSM state encoding and result status codes.
package hls_run_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_KRST   = 3'd1,
      S_START  = 3'd2,
      S_RUN    = 3'd3,
      S_REPORT = 3'd4,
      S_FINISH = 3'd5
   } state_t;

   localparam logic [1:0] ST_PASS      = 2'd0;
   localparam logic [1:0] ST_FAIL      = 2'd1;
   localparam logic [1:0] ST_TIMEOUT   = 2'd2;
   localparam logic [1:0] ST_UNCHECKED = 2'd3;

endpackage

// File: rtl/hls_run_sequencer_if.sv
// Result record stream of the HLS run sequencer (valid/ready with payload).
interface hls_run_sequencer_if #(
   parameter int CNT_W = 32,
   parameter int RUN_W = 8
);
   logic             res_valid;
   logic             res_ready;
   logic [1:0]       res_status;
   logic [CNT_W-1:0] res_cycles;
   logic [RUN_W-1:0] res_run_idx;

   modport master (
      output res_valid, res_status, res_cycles, res_run_idx,
      input  res_ready
   );

   modport slave (
      input  res_valid, res_status, res_cycles, res_run_idx,
      output res_ready
   );
endinterface

// File: rtl/hls_run_sequencer_done_collector.sv
// Sticky per-channel done/fail collector for the run sequencer.
// Optional macro HLS_RUN_CHECK_EN enables the sticky fail bits driven by check_fail.
module hls_done_collector #(
   parameter int NUM_CH = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              clr,
   input  logic              en,
   input  logic [NUM_CH-1:0] done_port,
   input  logic [NUM_CH-1:0] check_fail,
   output logic              all_done,
   output logic              any_fail
);

   logic [NUM_CH-1:0] done_q;
   logic [NUM_CH-1:0] done_in;

   // only the first done on a channel counts; later pulses are absorbed by done_q
   assign done_in  = done_port & {NUM_CH{en}};
   assign all_done = &(done_q | done_in);

   // sticky done bits, cleared when a new run is launched
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         done_q <= '0;
      end else if (clr) begin
         done_q <= '0;
      end else begin
         done_q <= done_q | done_in;
      end
   end

`ifdef HLS_RUN_CHECK_EN
   logic [NUM_CH-1:0] fail_q;
   logic [NUM_CH-1:0] fail_in;

   assign fail_in  = done_in & ~done_q & check_fail;
   assign any_fail = |(fail_q | fail_in);

   // sticky fail bits, captured only alongside a channel's first done
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fail_q <= '0;
      end else if (clr) begin
         fail_q <= '0;
      end else begin
         fail_q <= fail_q | fail_in;
      end
   end
`else
   logic unused_check_fail;

   assign unused_check_fail = ^check_fail;
   assign any_fail          = 1'b0;
`endif

endmodule

// File: rtl/hls_run_sequencer.sv
// Run controller for Bambu HLS kernels: resets, starts and times NUM_CH kernels
// for a programmed number of runs and streams one result record per run.
// Optional macro HLS_RUN_CHECK_EN: report PASS/FAIL from check_fail instead of UNCHECKED.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  S_IDLE   | waiting for go, kernels released (kernel_reset=1)
//  S_KRST   | kernels held in reset for RST_CYCLES cycles
//  S_START  | one-cycle start pulse, cycle counter = 1
//  S_RUN    | counting cycles until all channels done or timeout
//  S_REPORT | result record offered until accepted
//  S_FINISH | one-cycle seq_done pulse, then back to idle
module hls_run_sequencer
   import hls_run_pkg::*;
#(
   parameter int NUM_CH     = 1,
   parameter int CNT_W      = 32,
   parameter int RUN_W      = 8,
   parameter int TIMEOUT    = 200000000,
   parameter int RST_CYCLES = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              go,
   input  logic [RUN_W-1:0]  num_runs,
   output logic              kernel_reset,
   output logic [NUM_CH-1:0] start_port,
   input  logic [NUM_CH-1:0] done_port,
   input  logic [NUM_CH-1:0] check_fail,
   output logic              busy,
   output logic              seq_done,
   hls_run_sequencer_if.master res
);

   localparam int KRST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [KRST_W-1:0] KRST_LOAD = KRST_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);

   state_t            state_q;
   state_t            state_d;
   logic [KRST_W-1:0] krst_cnt_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [RUN_W-1:0]  num_runs_q;
   logic [RUN_W-1:0]  run_idx_q;
   logic              abort_q;
   logic              kernel_reset_q;
   logic [1:0]        res_status_q;
   logic [CNT_W-1:0]  res_cycles_q;

   logic              latch_go;
   logic              cap_done;
   logic              cap_tmo;
   logic              next_run;
   logic              last_run;
   logic              collecting;
   logic              enter_start;
   logic              all_done;
   logic              any_fail;
   logic [1:0]        ok_status;

   assign last_run    = (run_idx_q == num_runs_q - 1'b1);
   assign collecting  = (state_q == S_START) || (state_q == S_RUN);
   assign enter_start = (state_d == S_START);

`ifdef HLS_RUN_CHECK_EN
   assign ok_status = any_fail ? ST_FAIL : ST_PASS;
`else
   logic unused_any_fail;

   assign unused_any_fail = any_fail;
   assign ok_status       = ST_UNCHECKED;
`endif

   hls_done_collector #(.NUM_CH(NUM_CH)) u_done_collector (
      .clock      (clock),
      .reset      (reset),
      .clr        (enter_start),
      .en         (collecting),
      .done_port  (done_port),
      .check_fail (check_fail),
      .all_done   (all_done),
      .any_fail   (any_fail)
   );

   // state register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state decode; completion is checked before timeout so it wins a tie
   always_comb begin
      state_d  = state_q;
      latch_go = 1'b0;
      cap_done = 1'b0;
      cap_tmo  = 1'b0;
      next_run = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (go) begin
               latch_go = 1'b1;
               state_d  = S_KRST;
            end
         end
         S_KRST: begin
            if (krst_cnt_q == '0) begin
               state_d = S_START;
            end
         end
         S_START, S_RUN: begin
            if (all_done) begin
               cap_done = 1'b1;
               state_d  = S_REPORT;
            end else if (cnt_q >= TIMEOUT_C) begin
               cap_tmo = 1'b1;
               state_d = S_REPORT;
            end else begin
               state_d = S_RUN;
            end
         end
         S_REPORT: begin
            if (res.res_ready) begin
               if (abort_q || last_run) begin
                  state_d = S_FINISH;
               end else begin
                  next_run = 1'b1;
                  state_d  = S_KRST;
               end
            end
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // kernel reset is registered so it drops low in step with KRST and asserts on async reset
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         kernel_reset_q <= 1'b0;
      end else begin
         kernel_reset_q <= (state_d != S_KRST);
      end
   end

   // KRST down-counter and saturating run cycle counter
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         krst_cnt_q <= '0;
         cnt_q      <= '0;
      end else begin
         if (state_d == S_KRST && state_q != S_KRST) begin
            krst_cnt_q <= KRST_LOAD;
         end else if (state_q == S_KRST && krst_cnt_q != '0) begin
            krst_cnt_q <= krst_cnt_q - 1'b1;
         end
         if (enter_start) begin
            cnt_q <= CNT_W'(1);
         end else if (collecting && cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   // sequence bookkeeping and result payload capture
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         num_runs_q   <= '0;
         run_idx_q    <= '0;
         abort_q      <= 1'b0;
         res_status_q <= ST_PASS;
         res_cycles_q <= '0;
      end else begin
         if (latch_go) begin
            num_runs_q <= (num_runs == '0) ? RUN_W'(1) : num_runs;
            run_idx_q  <= '0;
            abort_q    <= 1'b0;
         end
         if (next_run) begin
            run_idx_q <= run_idx_q + 1'b1;
         end
         if (cap_done) begin
            res_status_q <= ok_status;
            res_cycles_q <= cnt_q;
         end
         if (cap_tmo) begin
            res_status_q <= ST_TIMEOUT;
            res_cycles_q <= TIMEOUT_C;
            abort_q      <= 1'b1;
         end
      end
   end

   assign kernel_reset    = kernel_reset_q;
   assign start_port      = {NUM_CH{state_q == S_START}};
   assign busy            = (state_q != S_IDLE);
   assign seq_done        = (state_q == S_FINISH);
   assign res.res_valid   = (state_q == S_REPORT);
   assign res.res_status  = res_status_q;
   assign res.res_cycles  = res_cycles_q;
   assign res.res_run_idx = run_idx_q;

endmodule

// File: tb/tb_hls_run_sequencer.sv
// Directed self-checking bench for hls_run_sequencer (NUM_CH=2, TIMEOUT=20, RST_CYCLES=2).
module tb_hls_run_sequencer;
   import hls_run_pkg::*;

`ifdef HLS_RUN_CHECK_EN
   localparam logic [31:0] EXP_OK  = 32'd0;
   localparam logic [31:0] EXP_BAD = 32'd1;
`else
   localparam logic [31:0] EXP_OK  = 32'd3;
   localparam logic [31:0] EXP_BAD = 32'd3;
`endif

   logic       clock;
   logic       reset;
   logic       go;
   logic [7:0] num_runs;
   logic       kernel_reset;
   logic [1:0] start_port;
   logic [1:0] done_port;
   logic [1:0] check_fail;
   logic       busy;
   logic       seq_done;

   int n_tests;
   int n_fail;

   hls_run_sequencer_if #(.CNT_W(16), .RUN_W(8)) res_if ();

   hls_run_sequencer #(
      .NUM_CH(2), .CNT_W(16), .RUN_W(8), .TIMEOUT(20), .RST_CYCLES(2)
   ) u_dut (
      .clock        (clock),
      .reset        (reset),
      .go           (go),
      .num_runs     (num_runs),
      .kernel_reset (kernel_reset),
      .start_port   (start_port),
      .done_port    (done_port),
      .check_fail   (check_fail),
      .busy         (busy),
      .seq_done     (seq_done),
      .res          (res_if)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(negedge clock);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic start_seq(input logic [7:0] n);
      go       = 1'b1;
      num_runs = n;
      tick();
      go       = 1'b0;
   endtask

   // waits for the start pulse, counting kernel_reset low cycles on the way
   task automatic wait_start(input int exp_lows);
      int lows = 0;
      int i    = 0;
      while (start_port == 2'b00 && i < 40) begin
         if (kernel_reset == 1'b0) lows++;
         tick();
         i++;
      end
      check("start_port", 32'(start_port), 32'd3);
      check("krst_lows", 32'(lows), 32'(exp_lows));
   endtask

   // called in the START cycle (counter=1); cycle k of the loop has counter value k
   task automatic pulse_run(input int c0, input int c1, input int c0b, input logic f0, input logic f1);
      int last = (c0 > c1) ? c0 : c1;
      for (int k = 1; k <= last; k++) begin
         done_port[0]  = (k == c0) || (k == c0b);
         done_port[1]  = (k == c1);
         check_fail[0] = f0 && done_port[0];
         check_fail[1] = f1 && done_port[1];
         tick();
      end
      done_port  = 2'b00;
      check_fail = 2'b00;
   endtask

   task automatic accept(input logic [31:0] st, input logic [31:0] cyc, input logic [31:0] idx);
      check("res_valid", 32'(res_if.res_valid), 32'd1);
      check("res_status", 32'(res_if.res_status), st);
      check("res_cycles", 32'(res_if.res_cycles), cyc);
      check("res_run_idx", 32'(res_if.res_run_idx), idx);
      res_if.res_ready = 1'b1;
      tick();
      res_if.res_ready = 1'b0;
   endtask

   task automatic finish_check();
      check("seq_done_hi", 32'(seq_done), 32'd1);
      check("finish_krst", 32'(kernel_reset), 32'd1);
      tick();
      check("seq_done_lo", 32'(seq_done), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      int n;
      int starts;
      n_tests = 0;
      n_fail  = 0;
      clock = 1'b0;
      reset = 1'b0;
      go = 1'b0;
      num_runs = 8'd0;
      done_port = 2'b00;
      check_fail = 2'b00;
      res_if.res_ready = 1'b0;

      // reset values
      tick();
      tick();
      check("rst_krst", 32'(kernel_reset), 32'd0);
      check("rst_start", 32'(start_port), 32'd0);
      check("rst_valid", 32'(res_if.res_valid), 32'd0);
      check("rst_status", 32'(res_if.res_status), 32'd0);
      check("rst_cycles", 32'(res_if.res_cycles), 32'd0);
      check("rst_idx", 32'(res_if.res_run_idx), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_seq_done", 32'(seq_done), 32'd0);
      reset = 1'b1;
      tick();
      check("idle_krst", 32'(kernel_reset), 32'd1);

      // 1: single run, done 10 cycles after start -> 11 cycles; go in FINISH ignored
      start_seq(8'd1);
      wait_start(2);
      pulse_run(11, 11, 0, 1'b0, 1'b0);
      accept(EXP_OK, 32'd11, 32'd0);
      check("t1_seq_done", 32'(seq_done), 32'd1);
      go = 1'b1;
      tick();
      go = 1'b0;
      check("t1_idle", 32'(busy), 32'd0);
      tick();
      check("t1_go_ignored", 32'(busy), 32'd0);

      // 2a: staggered done, ch0 pulsed twice -> 7 cycles
      start_seq(8'd1);
      wait_start(2);
      pulse_run(3, 7, 5, 1'b0, 1'b0);
      accept(EXP_OK, 32'd7, 32'd0);
      finish_check();

      // 2b: three runs, each preceded by two kernel_reset low cycles
      start_seq(8'd3);
      for (int r = 0; r < 3; r++) begin
         wait_start(2);
         pulse_run(2, 4, 0, 1'b0, 1'b0);
         accept(EXP_OK, 32'd4, 32'(r));
      end
      finish_check();

      // 3: timeout aborts the sequence after one record
      start_seq(8'd3);
      wait_start(2);
      n = 0;
      while (!res_if.res_valid && n < 40) begin
         tick();
         n++;
      end
      check("t3_tmo_latency", 32'(n), 32'd20);
      accept(32'd2, 32'd20, 32'd0);
      check("t3_seq_done", 32'(seq_done), 32'd1);
      starts = 0;
      repeat (10) begin
         tick();
         if (start_port != 2'b00) starts++;
      end
      check("t3_no_restart", 32'(starts), 32'd0);

      // 4: check_fail on ch1's done; num_runs=0 behaves as one run
      start_seq(8'd0);
      wait_start(2);
      pulse_run(2, 5, 0, 1'b0, 1'b1);
      accept(EXP_BAD, 32'd5, 32'd0);
      finish_check();

      // 5: consumer stalls 5 cycles, then second run proceeds
      start_seq(8'd2);
      wait_start(2);
      pulse_run(3, 3, 0, 1'b0, 1'b0);
      repeat (5) begin
         check("t5_valid", 32'(res_if.res_valid), 32'd1);
         check("t5_cycles", 32'(res_if.res_cycles), 32'd3);
         check("t5_idx", 32'(res_if.res_run_idx), 32'd0);
         check("t5_no_start", 32'(start_port), 32'd0);
         tick();
      end
      accept(EXP_OK, 32'd3, 32'd0);
      wait_start(2);
      pulse_run(6, 2, 0, 1'b0, 1'b0);
      accept(EXP_OK, 32'd6, 32'd1);
      finish_check();

      // 7: done in START cycle -> 1; done exactly at TIMEOUT -> completion wins
      start_seq(8'd2);
      wait_start(2);
      pulse_run(1, 1, 0, 1'b0, 1'b0);
      accept(EXP_OK, 32'd1, 32'd0);
      wait_start(2);
      pulse_run(20, 20, 0, 1'b0, 1'b0);
      accept(EXP_OK, 32'd20, 32'd1);
      finish_check();

      // 6: asynchronous reset mid-RUN
      start_seq(8'd1);
      wait_start(2);
      tick();
      tick();
      tick();
      reset = 1'b0;
      #1;
      check("t6_krst", 32'(kernel_reset), 32'd0);
      check("t6_busy", 32'(busy), 32'd0);
      check("t6_start", 32'(start_port), 32'd0);
      check("t6_valid", 32'(res_if.res_valid), 32'd0);
      check("t6_status", 32'(res_if.res_status), 32'd0);
      check("t6_cycles", 32'(res_if.res_cycles), 32'd0);
      check("t6_idx", 32'(res_if.res_run_idx), 32'd0);
      tick();
      reset = 1'b1;
      done_port = 2'b11;
      tick();
      done_port = 2'b00;
      tick();
      check("t6_no_record", 32'(res_if.res_valid), 32'd0);
      check("t6_idle", 32'(busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/hls_run_sequencer.md
Name: hls_run_sequencer

Overview:
Synthesizable run controller for Bambu-generated HLS kernels. It replaces the ad-hoc simulation-only start/done sequencing with hardware.
- Resets NUM_CH kernel instances, issues start pulses and waits until every channel has reported done.
- Counts cycles per run and applies a watchdog timeout.
- Repeats for a programmed number of runs, streaming one result record per run over a valid/ready interface.
- Sits between the board-level control logic and the kernel `main` instances.

Parameters:
- NUM_CH, 1: number of kernel instances started in lockstep.
- CNT_W, 32: cycle-counter width.
- RUN_W, 8: width of run count and run index.
- TIMEOUT, 200000000: cycle limit per run. A run exceeding it aborts the sequence.
- RST_CYCLES, 2: cycles kernel_reset is held asserted before each start.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- go  in  1  one-cycle request to begin a sequence; ignored unless idle.
- num_runs  in  RUN_W  runs to execute; sampled on the go cycle; 0 is treated as 1.
- kernel_reset  out  1  active-low reset to kernels.
- start_port  out  NUM_CH  start pulse per kernel.
- done_port  in  NUM_CH  kernel done pulses.
- check_fail  in  NUM_CH  kernel self-check failure; sampled in the same cycle as that channel's done_port.
- res_valid  out  1  result record valid.
- res_ready  in  1  consumer accepts the record.
- res_status  out  2  0=PASS, 1=FAIL, 2=TIMEOUT, 3=UNCHECKED.
- res_cycles  out  CNT_W  cycles of the run.
- res_run_idx  out  RUN_W  0-based run index.
- busy  out  1  high whenever the state is not IDLE.
- seq_done  out  1  one-cycle pulse when the sequence finishes or aborts.

Behaviour:
- Reset values:
  - kernel_reset=0 (kernels held in reset).
  - start_port=0, res_valid=0, res_status=0, res_cycles=0, res_run_idx=0, busy=0, seq_done=0.
  - FSM in IDLE; all counters and sticky flags cleared.
- FSM states: IDLE, KRST, START, RUN, REPORT, FINISH.
- IDLE:
  - kernel_reset=1.
  - On go: latch num_runs (0 is replaced by 1), clear run index, go to KRST.
- KRST: kernel_reset=0 for exactly RST_CYCLES cycles, then START.
- START:
  - start_port = all ones for exactly one cycle.
  - Cycle counter loads 1 and the done-collector clears.
  - Next state is RUN.
- RUN:
  - Counter increments by 1 each cycle and saturates at all ones.
  - Each channel's done_port sets a sticky done bit; check_fail at that same cycle sets a sticky fail bit.
  - A done in the START cycle is captured.
  - When all done bits are set (including the bit set in this cycle), latch res_cycles = counter value this cycle and go to REPORT.
  - Cycle counting is inclusive: a done in the START cycle gives res_cycles=1.
  - Repeated done pulses on an already-done channel are ignored.
- Timeout: if the counter reaches TIMEOUT without all channels done:
  - res_status=TIMEOUT, res_cycles=TIMEOUT.
  - Go to REPORT and flag an abort.
  - If completion and timeout fall in the same cycle, completion wins.
- REPORT:
  - res_valid held high with stable payload until res_ready is high. Transfer happens on the cycle where both are high.
  - After transfer: on abort or last run, go to FINISH. Otherwise increment the run index and go to KRST.
  - res_ready asserted before res_valid has no effect.
- FINISH: seq_done=1 for one cycle, kernel_reset stays 1, return to IDLE.
- go while busy is ignored, including in the FINISH cycle.
- Asynchronous reset mid-run:
  - Immediate return to reset values. No result is emitted for the interrupted run.
  - kernel_reset asserts asynchronously.
- Status priority: TIMEOUT > FAIL > PASS.

Optional Feature:
- HLS_RUN_CHECK_EN defined: check_fail is used and status is PASS or FAIL as above.
- HLS_RUN_CHECK_EN undefined:
  - check_fail is unused and the sticky fail logic is removed.
  - Completed runs report UNCHECKED (3); TIMEOUT is unchanged.

Decomposition:
- Package hls_run_pkg holds:
  - the state enum;
  - the res_status codes ST_PASS, ST_FAIL, ST_TIMEOUT, ST_UNCHECKED.
- Sub-module hls_done_collector (NUM_CH wide):
  - sticky done/fail bits with a synchronous clear;
  - all_done output that includes the current-cycle done_port.

Test Plan:
1. NUM_CH=1, num_runs=1, done 10 cycles after the start cycle, check_fail=0 -> one record: status 0, cycles 11, idx 0; then seq_done pulse.
2. NUM_CH=2, done on ch0 at cycle 3 and ch1 at cycle 7 (ch0 pulsed twice) -> cycles 7; a second num_runs=3 sequence yields idx 0,1,2, each preceded by 2 low cycles on kernel_reset.
3. TIMEOUT=20, done never arrives, num_runs=3 -> a single record with status 2, cycles 20; then FINISH, with no further starts.
4. check_fail=1 with done on ch1 only -> status 1 with HLS_RUN_CHECK_EN defined; status 3 without it.
5. Hold res_ready=0 for 5 cycles -> res_valid and payload stable, and no new start_port until acceptance.
6. Assert reset low mid-RUN -> all outputs return to reset values immediately, and no record is emitted.
